fighter_action_sequencer: RTL and testbench

//   Per-player action scheduler between keyboard decode and the sprite/collision logic.

---
 rtl/fighter_action_sequencer.sv | 153 +++++++++++++++
 tb/tb_fighter_action_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fighter_action_sequencer.sv
// Per-player action scheduler: arbitrates action/walk keys, times one animation, stun or cooldown at a time on frame_tick.
// Latency: every output is registered and reflects the inputs sampled at the previous Clk edge.
// Backpressure: none; keys arriving outside IDLE/WALK are dropped, and a key still held is re-sampled once IDLE is reached.
module fighter_action_sequencer #(
    parameter int PUNCH_FRAMES = 8,
    parameter int KICK_FRAMES  = 12,
    parameter int JUMP_FRAMES  = 24,
    parameter int DODGE_FRAMES = 10,
    parameter int STUN_FRAMES  = 16,
    parameter int COOL_FRAMES  = 4,
    parameter int HIT_START    = 2,
    parameter int HIT_END      = 5,
    parameter int CNT_W        = 6
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_tick,
    input  logic             left,
    input  logic             right,
    input  logic             stand,
    input  logic             fight,
    input  logic             kick,
    input  logic             jump,
    input  logic             dodge,
    input  logic             hit_in,
    input  logic             facing_left,
    output logic [2:0]       action,
    output logic [CNT_W-1:0] action_frame,
    output logic             act_facing_left,
    output logic             move_left,
    output logic             move_right,
    output logic             attack_active,
    output logic             busy,
    output logic             cmd_ack
);

    // The state register is the externally visible action code; the four ACT
    // sub-states are simply the four attack/movement codes.
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WALK  = 3'd1;
    localparam logic [2:0] S_PUNCH = 3'd2;
    localparam logic [2:0] S_KICK  = 3'd3;
    localparam logic [2:0] S_JUMP  = 3'd4;
    localparam logic [2:0] S_DODGE = 3'd5;
    localparam logic [2:0] S_STUN  = 3'd6;
    localparam logic [2:0] S_COOL  = 3'd7;

    localparam logic [CNT_W-1:0] PUNCH_LAST = CNT_W'(PUNCH_FRAMES - 1);
    localparam logic [CNT_W-1:0] KICK_LAST  = CNT_W'(KICK_FRAMES - 1);
    localparam logic [CNT_W-1:0] JUMP_LAST  = CNT_W'(JUMP_FRAMES - 1);
    localparam logic [CNT_W-1:0] DODGE_LAST = CNT_W'(DODGE_FRAMES - 1);
    localparam logic [CNT_W-1:0] STUN_LAST  = CNT_W'(STUN_FRAMES - 1);
    // Meaningless when COOL_FRAMES==0 because COOL is then never entered.
    localparam logic [CNT_W-1:0] COOL_LAST  = CNT_W'(COOL_FRAMES - 1);
    localparam bit               HAS_COOL   = (COOL_FRAMES != 0);

    logic [2:0]       nxt_action;
    logic [CNT_W-1:0] nxt_frame;
    logic [CNT_W-1:0] last_frame;
    logic [2:0]       req;
    logic             nxt_ack;
    logic             nxt_ml;
    logic             nxt_mr;
    logic             nxt_fac;

    // Final frame index of whichever timed state is currently running.
    always_comb begin
        case (action)
            S_PUNCH: last_frame = PUNCH_LAST;
            S_KICK:  last_frame = KICK_LAST;
            S_JUMP:  last_frame = JUMP_LAST;
            S_DODGE: last_frame = DODGE_LAST;
            S_STUN:  last_frame = STUN_LAST;
            default: last_frame = COOL_LAST;
        endcase
    end

    // Next-state decision: a landed hit beats everything, then key arbitration or frame timing.
    always_comb begin
        nxt_action = action;
        nxt_frame  = action_frame;
        nxt_ack    = 1'b0;
        nxt_ml     = 1'b0;
        nxt_mr     = 1'b0;
        nxt_fac    = act_facing_left;
        req        = dodge ? S_DODGE :
                     jump  ? S_JUMP  :
                     kick  ? S_KICK  :
                     fight ? S_PUNCH : S_IDLE;

        if (hit_in && action != S_DODGE) begin
            nxt_action = S_STUN;
            nxt_frame  = '0;
        end else begin
            case (action)
                S_IDLE, S_WALK: begin
                    nxt_frame = '0;
                    if (req != S_IDLE) begin
                        nxt_action = req;
                        nxt_fac    = facing_left;
                        nxt_ack    = 1'b1;
                    end else if ((left ^ right) && !stand) begin
                        nxt_action = S_WALK;
                        nxt_ml     = left;
                        nxt_mr     = right;
                    end else begin
                        nxt_action = S_IDLE;
                    end
                end
                default: begin
                    if (frame_tick) begin
                        if (action_frame == last_frame) begin
                            nxt_frame = '0;
                            if (action == S_COOL || !HAS_COOL)
                                nxt_action = S_IDLE;
                            else
                                nxt_action = S_COOL;
                        end else begin
                            nxt_frame = action_frame + CNT_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    // Register the state and all outputs; flags are derived from the next state so they line up with it.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            action          <= S_IDLE;
            action_frame    <= '0;
            act_facing_left <= 1'b0;
            move_left       <= 1'b0;
            move_right      <= 1'b0;
            attack_active   <= 1'b0;
            busy            <= 1'b0;
            cmd_ack         <= 1'b0;
        end else begin
            action          <= nxt_action;
            action_frame    <= nxt_frame;
            act_facing_left <= nxt_fac;
            move_left       <= nxt_ml;
            move_right      <= nxt_mr;
            cmd_ack         <= nxt_ack;
            busy            <= !(nxt_action == S_IDLE || nxt_action == S_WALK);
            // The frame never passes the last index, so a late HIT_END clips itself.
            attack_active   <= (nxt_action == S_PUNCH || nxt_action == S_KICK) &&
                               (32'(nxt_frame) >= HIT_START) &&
                               (32'(nxt_frame) < HIT_END);
        end
    end

endmodule

// File: tb/tb_fighter_action_sequencer.sv
// Bench for fighter_action_sequencer: directed scenarios followed by a long randomized run.
// Every cycle is compared against a remaining-ticks reference model of the action rules.
// Inputs change 1 time unit after each rising edge; outputs are sampled at that same point.
module tb_fighter_action_sequencer;

    localparam int PF = 8, KF = 12, JF = 24, DF = 10, SF = 16, CF = 4;
    localparam int HS = 2, HE = 5, CW = 6;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          frame_tick = 1'b0;
    logic          left = 1'b0, right = 1'b0, stand = 1'b0;
    logic          fight = 1'b0, kick = 1'b0, jump = 1'b0, dodge = 1'b0;
    logic          hit_in = 1'b0, facing_left = 1'b0;
    logic [2:0]    action;
    logic [CW-1:0] action_frame;
    logic          act_facing_left, move_left, move_right, attack_active, busy, cmd_ack;

    int checks = 0;
    int errors = 0;

    // Reference model: action code, length of the running timed phase, ticks still to go.
    int m_act = 0, m_len = 0, m_rem = 0, m_fac = 0, m_ml = 0, m_mr = 0, m_ack = 0;

    fighter_action_sequencer #(
        .PUNCH_FRAMES(PF), .KICK_FRAMES(KF), .JUMP_FRAMES(JF), .DODGE_FRAMES(DF),
        .STUN_FRAMES(SF), .COOL_FRAMES(CF), .HIT_START(HS), .HIT_END(HE), .CNT_W(CW)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
        .left(left), .right(right), .stand(stand),
        .fight(fight), .kick(kick), .jump(jump), .dodge(dodge),
        .hit_in(hit_in), .facing_left(facing_left),
        .action(action), .action_frame(action_frame), .act_facing_left(act_facing_left),
        .move_left(move_left), .move_right(move_right), .attack_active(attack_active),
        .busy(busy), .cmd_ack(cmd_ack)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int len_of(input int a);
        case (a)
            2: return PF;
            3: return KF;
            4: return JF;
            5: return DF;
            6: return SF;
            7: return CF;
            default: return 0;
        endcase
    endfunction

    // Advance the model by one clock using the inputs that were present at the edge.
    task automatic model_step();
        int req;
        m_ack = 0;
        m_ml  = 0;
        m_mr  = 0;
        if (Reset) begin
            m_act = 0; m_len = 0; m_rem = 0; m_fac = 0;
        end else if (hit_in && m_act != 5) begin
            m_act = 6; m_len = SF; m_rem = SF;
        end else if (m_act <= 1) begin
            req = dodge ? 5 : jump ? 4 : kick ? 3 : fight ? 2 : 0;
            if (req != 0) begin
                m_act = req; m_len = len_of(req); m_rem = m_len;
                m_fac = facing_left; m_ack = 1;
            end else if (!stand && left != right) begin
                m_act = 1; m_ml = left; m_mr = right;
            end else begin
                m_act = 0;
            end
        end else if (frame_tick) begin
            m_rem--;
            if (m_rem == 0) begin
                if (m_act != 7 && CF > 0) begin
                    m_act = 7; m_len = CF; m_rem = CF;
                end else begin
                    m_act = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        int f;
        f = (m_act <= 1) ? 0 : m_len - m_rem;
        check("action", action, m_act);
        check("frame", action_frame, f);
        check("ack", cmd_ack, m_ack);
        check("busy", busy, (m_act >= 2) ? 1 : 0);
        check("move_l", move_left, m_ml);
        check("move_r", move_right, m_mr);
        check("attack", attack_active,
              ((m_act == 2 || m_act == 3) && f >= HS && f < HE && f < m_len) ? 1 : 0);
        if (m_act >= 2 && m_act <= 5) check("facing", act_facing_left, m_fac);
    endtask

    task automatic step();
        @(posedge Clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1; step();
            frame_tick = 1'b0; step();
        end
    endtask

    initial begin
        int acnt;
        step(); step();
        Reset = 1'b0;
        check("rst_action", action, 0);
        check("rst_frame", action_frame, 0);

        // Kick, full animation, cooldown.
        kick = 1'b1; step(); kick = 1'b0;
        check("kick_ack", cmd_ack, 1);
        check("kick_act", action, 3);
        step();
        check("ack_pulse", cmd_ack, 0);
        tick_n(KF);
        check("kick_cool", action, 7);
        tick_n(CF);
        check("cool_idle", action, 0);

        // Priority and refire of a key held through the action.
        kick = 1'b1; fight = 1'b1; dodge = 1'b1; step();
        check("prio_dodge", action, 5);
        dodge = 1'b0;
        tick_n(DF + CF);
        check("held_refire", action, 3);
        kick = 1'b0; fight = 1'b0;
        tick_n(KF + CF);

        // Punch hit window.
        fight = 1'b1; step(); fight = 1'b0;
        acnt = 0;
        for (int f = 0; f < PF; f++) begin
            check("win_frame", action_frame, f);
            check("win_attack", attack_active, (f >= HS && f < HE) ? 1 : 0);
            acnt += int'(attack_active);
            tick_n(1);
        end
        check("win_count", acnt, 3);
        tick_n(CF);

        // Hit during punch, then hit ignored during dodge.
        fight = 1'b1; step(); fight = 1'b0;
        tick_n(3);
        hit_in = 1'b1; step(); hit_in = 1'b0;
        check("hit_stun", action, 6);
        check("hit_attack", attack_active, 0);
        tick_n(SF);
        check("stun_cool", action, 7);
        tick_n(CF);
        dodge = 1'b1; step(); dodge = 1'b0;
        tick_n(3);
        hit_in = 1'b1; step(); hit_in = 1'b0;
        check("dodge_inv", action, 5);
        check("dodge_frame", action_frame, 3);
        tick_n(DF - 3 + CF);

        // Walking, then jump preempts walk, then reset mid-jump.
        right = 1'b1; step();
        check("walk_r", action, 1);
        check("walk_mr", move_right, 1);
        left = 1'b1; step();
        check("both_idle", action, 0);
        right = 1'b0; step();
        check("walk_ml", move_left, 1);
        facing_left = 1'b1; jump = 1'b1; step(); jump = 1'b0; left = 1'b0;
        check("jump_act", action, 4);
        check("jump_ml", move_left, 0);
        check("jump_face", act_facing_left, 1);
        tick_n(5);
        Reset = 1'b1; step(); Reset = 1'b0;
        check("rst_mid", action, 0);
        check("rst_busy", busy, 0);
        step();
        check("no_cool", action, 0);

        // Randomized run.
        for (int c = 0; c < 20000; c++) begin
            frame_tick  = ($urandom_range(0, 2) == 0);
            fight       = ($urandom_range(0, 19) == 0);
            kick        = ($urandom_range(0, 19) == 0);
            jump        = ($urandom_range(0, 29) == 0);
            dodge       = ($urandom_range(0, 29) == 0);
            hit_in      = ($urandom_range(0, 79) == 0);
            stand       = ($urandom_range(0, 9) == 0);
            facing_left = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 7) == 0) left = ~left;
            if ($urandom_range(0, 7) == 0) right = ~right;
            Reset       = ($urandom_range(0, 999) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
